vending_change_dispenser: RTL and testbench
===========================================

Name: vending_change_dispenser

Overview:
- Coin-return unit on the payout side of the vending machine.
- Drives coins out in the same coin-value encoding the machine accepts on its coin input (8-bit value, one coin per cycle, 0 = none).
- On a refund request it latches an amount and emits a greedy sequence of coins (50/10/5/1), one coin per clock, then pulses done.
- Sits between the vending FSM's refund/total_money output and the coin hopper drivers.

Parameters:
- DENOM0, 50, largest coin value (8-bit).
- DENOM1, 10, second coin value.
- DENOM2, 5, third coin value.
- DENOM3, 1, smallest coin value. Must be 1 so any amount is reachable.
- STOCK0..STOCK3, 4/8/4/16, initial coin count per denomination (8-bit each). Used only with COIN_INVENTORY_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- refund_req  in  1  request pulse; sampled only in IDLE.
- refund_amount  in  8  amount to return, unsigned; sampled with refund_req.
- coin_out  out  8  value of coin dispensed this cycle; 0 when none.
- coin_valid  out  1  high exactly when coin_out is nonzero.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse at end of each request.
- remaining  out  8  amount still owed (registered).
- error  out  1  refund incomplete; sticky until next accepted request.

Behaviour:
- Reset (reset==0 at clk edge):
  - State goes to IDLE.
  - coin_out=0, coin_valid=0, busy=0, done=0, remaining=0, error=0.
  - Inventory counters reload from STOCK0..3.
  - Reset dominates everything and aborts any dispense in progress immediately; the remaining coins are not emitted.
- States: IDLE, DISPENSE, DONE. All outputs are registered.
- IDLE, refund_req==1 at edge T:
  - At T: remaining<=refund_amount, busy<=1, error<=0.
  - If refund_amount==0, next state is DONE; otherwise DISPENSE.
- DISPENSE, each edge:
  - Select the largest DENOMk <= remaining, checked in order 50, 10, 5, 1 (with inventory: also requires stockk>0).
  - coin_out<=DENOMk, coin_valid<=1, remaining<=remaining-DENOMk.
  - If remaining-DENOMk==0, next state is DONE.
  - First coin appears on outputs one cycle after acceptance.
  - Coin count for amount A is the greedy count. Examples: 87 gives 7 coins, 255 gives 6 coins.
- DONE, one cycle:
  - done<=1, coin_out<=0, coin_valid<=0, busy<=0.
  - Next state IDLE; done drops the following cycle.
  - Earliest next acceptance is the cycle after done is high.
- refund_req while busy or in DONE: ignored, not queued. refund_amount changes during dispense have no effect.
- Subtraction is 8-bit; the greedy rule guarantees no underflow.
- The design never emits a coin greater than remaining.

Optional Feature:
- Macro: COIN_INVENTORY_EN.
- Defined:
  - Four 8-bit stock counters are loaded from STOCK0..3 at reset.
  - Each emitted coin decrements its own counter.
  - A denomination with stock 0 is skipped.
  - If remaining>0 and no eligible denomination exists in DISPENSE: no coin that cycle, error<=1, go to DONE. remaining holds the unpaid amount.
  - Counters persist across requests and reload only at reset.
- Undefined:
  - Stock is unlimited; no counters are synthesised.
  - error is tied to 0.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> all outputs 0, busy=0; no coins for 5 idle cycles.
- refund_amount=87, refund_req 1 cycle -> coin_out 50,10,10,10,5,1,1 on 7 consecutive cycles starting 1 cycle after request, coin_valid matching; then done pulse 1 cycle; remaining ends 0; busy high for 8 cycles.
- refund_amount=0 -> no coin_valid; done pulses 1 cycle after acceptance; error=0.
- refund_amount=255, second refund_req=20 asserted mid-dispense -> only 50x5, 5 emitted (6 coins); second request ignored; done once.
- reset=0 asserted during third coin of a 87 refund -> next cycle all outputs 0, state IDLE; a new request of 15 then yields 10,5, done.
- With COIN_INVENTORY_EN, STOCK0=1, STOCK1=2, STOCK2=1, STOCK3=2, request 80 -> 50,10,10,5,1,1 then done with error=1, remaining=3. A following request of 1 -> no coin, done, error=1, remaining=1.

Source files
------------

// File: rtl/vending_change_dispenser.sv
// vending_change_dispenser: coin-return unit. On a refund request it latches
// the amount and pays it out greedily (largest coin first), one coin per clock,
// then pulses done for one cycle.
//
// Build option: define COIN_INVENTORY_EN to add per-denomination stock
// counters (loaded from STOCK0..3 at reset); an exhausted denomination is
// skipped and an unpayable remainder raises a sticky error.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-low reset
//   refund_req    in   request pulse, sampled only while idle
//   refund_amount in   [7:0] amount to return, sampled with refund_req
//   coin_out      out  [7:0] coin value dispensed this cycle, 0 when none
//   coin_valid    out  high exactly when coin_out is nonzero
//   busy          out  high from the cycle after acceptance until done
//   done          out  one-cycle pulse at the end of each request
//   remaining     out  [7:0] amount still owed
//   error         out  refund incomplete; sticky until next accepted request
module vending_change_dispenser #(
  parameter logic [7:0] DENOM0 = 8'd50,
  parameter logic [7:0] DENOM1 = 8'd10,
  parameter logic [7:0] DENOM2 = 8'd5,
  parameter logic [7:0] DENOM3 = 8'd1
`ifdef COIN_INVENTORY_EN
  ,
  parameter logic [7:0] STOCK0 = 8'd4,
  parameter logic [7:0] STOCK1 = 8'd8,
  parameter logic [7:0] STOCK2 = 8'd4,
  parameter logic [7:0] STOCK3 = 8'd16
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refund_req,
  input  logic [7:0] refund_amount,
  output logic [7:0] coin_out,
  output logic       coin_valid,
  output logic       busy,
  output logic       done,
  output logic [7:0] remaining,
  output logic       error
);

  localparam int unsigned W    = 8;
  localparam int unsigned NDEN = 4;
  localparam int unsigned IW   = 2;

  typedef enum logic [1:0] {IDLE, DISPENSE, DONE} state_t;

  state_t state, state_d;

  logic [W-1:0]            coin_out_d, remaining_d;
  logic                    coin_valid_d, busy_d, done_d, error_d;
  logic [NDEN-1:0][W-1:0]  denom;
  logic [NDEN-1:0]         avail;
  logic                    sel_hit;
  logic [IW-1:0]           sel_idx;

  // Index 0 is the largest coin and has the highest priority.
  assign denom = {DENOM3, DENOM2, DENOM1, DENOM0};

`ifdef COIN_INVENTORY_EN
  logic [NDEN-1:0][W-1:0] stock, stock_d;

  always_comb begin
    for (int k = 0; k < NDEN; k++) begin
      avail[k] = (stock[k] != '0);
    end
  end
`else
  assign avail = '1;
`endif

  // Priority select: the largest available coin not exceeding what is owed.
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    for (int k = NDEN - 1; k >= 0; k--) begin
      if (avail[k] && (denom[k] != '0) && (denom[k] <= remaining)) begin
        sel_hit = 1'b1;
        sel_idx = IW'(k);
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    coin_out_d   = '0;
    coin_valid_d = 1'b0;
    busy_d       = busy;
    done_d       = 1'b0;
    remaining_d  = remaining;
    error_d      = error;
`ifdef COIN_INVENTORY_EN
    stock_d      = stock;
`endif
    unique case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (refund_req) begin
          remaining_d = refund_amount;
          busy_d      = 1'b1;
          error_d     = 1'b0;
          state_d     = (refund_amount == '0) ? DONE : DISPENSE;
        end
      end
      DISPENSE: begin
        if (sel_hit) begin
          coin_out_d   = denom[sel_idx];
          coin_valid_d = 1'b1;
          remaining_d  = remaining - denom[sel_idx];
`ifdef COIN_INVENTORY_EN
          stock_d[sel_idx] = stock[sel_idx] - W'(1);
`endif
          if (remaining_d == '0) begin
            state_d = DONE;
          end
        end else begin
          // Nothing payable: finish with the unpaid amount left in remaining.
`ifdef COIN_INVENTORY_EN
          error_d = 1'b1;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      coin_out   <= '0;
      coin_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      remaining  <= '0;
      error      <= 1'b0;
`ifdef COIN_INVENTORY_EN
      stock      <= {STOCK3, STOCK2, STOCK1, STOCK0};
`endif
    end else begin
      state      <= state_d;
      coin_out   <= coin_out_d;
      coin_valid <= coin_valid_d;
      busy       <= busy_d;
      done       <= done_d;
      remaining  <= remaining_d;
      error      <= error_d;
`ifdef COIN_INVENTORY_EN
      stock      <= stock_d;
`endif
    end
  end

endmodule

// File: tb/tb_vending_change_dispenser.sv
// Bench for vending_change_dispenser: table of refund requests plus
// hand-written reset-abort and inventory sequences; expected coins come from
// a greedy reference model pushed into a scoreboard queue.
module tb_vending_change_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       refund_req;
  logic [7:0] refund_amount;
  logic [7:0] coin_out;
  logic       coin_valid;
  logic       busy;
  logic       done;
  logic [7:0] remaining;
  logic       error;

  always #5 clk = ~clk;

`ifdef COIN_INVENTORY_EN
  vending_change_dispenser #(
    .STOCK0(8'd1), .STOCK1(8'd2), .STOCK2(8'd1), .STOCK3(8'd2)
  ) dut (
`else
  vending_change_dispenser dut (
`endif
    .clk(clk), .reset(reset), .refund_req(refund_req),
    .refund_amount(refund_amount), .coin_out(coin_out),
    .coin_valid(coin_valid), .busy(busy), .done(done),
    .remaining(remaining), .error(error)
  );

  int checks = 0;
  int fails  = 0;
  logic [7:0] exp_q[$];
  int stock_m[4];
  int den_m[4] = '{50, 10, 5, 1};

  typedef struct {
    logic [7:0] amt;
    int         intr_at;
    logic [7:0] intr_amt;
    int         exp_n;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic reload_stock();
`ifdef COIN_INVENTORY_EN
    stock_m = '{1, 2, 1, 2};
`else
    stock_m = '{255, 255, 255, 255};
`endif
  endtask

  // Greedy reference: pushes expected coins, reports count and unpaid rest.
  task automatic model_push(input int amt, output int ncoins, output int unpaid, output bit err);
    int  rem;
    bit  hit;
    rem = amt;
    ncoins = 0;
    err = 1'b0;
    while (rem > 0 && !err) begin
      hit = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (!hit && den_m[k] <= rem && stock_m[k] > 0) begin
          hit = 1'b1;
          exp_q.push_back(8'(den_m[k]));
          rem -= den_m[k];
          ncoins++;
`ifdef COIN_INVENTORY_EN
          stock_m[k]--;
`endif
        end
      end
      if (!hit) err = 1'b1;
    end
    unpaid = rem;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_coin_out"}, int'(coin_out), 0);
    check({tag, "_coin_valid"}, int'(coin_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    refund_req = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    check("reset_remaining", int'(remaining), 0);
    check("reset_error", int'(error), 0);
    reset = 1'b1;
    reload_stock();
    exp_q.delete();
  endtask

  // One request; optional intruding request driven during cycle intr_at.
  task automatic do_refund(input logic [7:0] amt, input int intr_at,
                           input logic [7:0] intr_amt, input int exp_n);
    int nc, unpaid, done_at, n, busy_cnt, coin_cnt, exp_rem;
    bit err, seen_done;
    logic [7:0] e;
    exp_q.delete();
    model_push(int'(amt), nc, unpaid, err);
    done_at   = (amt == 8'd0) ? 1 : nc + 1 + (err ? 1 : 0);
    exp_rem   = int'(amt);
    n         = 0;
    busy_cnt  = 0;
    coin_cnt  = 0;
    seen_done = 1'b0;
    @(negedge clk);
    refund_req    = 1'b1;
    refund_amount = amt;
    @(negedge clk);
    check($sformatf("accept_busy_%0d", amt), int'(busy), 1);
    check($sformatf("accept_error_%0d", amt), int'(error), 0);
    check($sformatf("accept_remaining_%0d", amt), int'(remaining), int'(amt));
    while (!seen_done && n <= 60) begin
      if (busy) busy_cnt++;
      check($sformatf("valid_vs_coin_%0d_n%0d", amt, n), int'(coin_valid), int'(coin_out != 8'd0));
      if (coin_valid) begin
        coin_cnt++;
        if (exp_q.size() == 0) begin
          check($sformatf("extra_coin_%0d", amt), int'(coin_out), 0);
        end else begin
          e = exp_q.pop_front();
          exp_rem -= int'(e);
          check($sformatf("coin_%0d_n%0d", amt, n), int'(coin_out), int'(e));
          check($sformatf("rem_%0d_n%0d", amt, n), int'(remaining), exp_rem);
        end
      end
      if (done) begin
        seen_done = 1'b1;
        check($sformatf("done_cycle_%0d", amt), n, done_at);
        check($sformatf("done_remaining_%0d", amt), int'(remaining), unpaid);
        check($sformatf("done_error_%0d", amt), int'(error), int'(err));
      end
      refund_req    = (n == intr_at);
      refund_amount = (n == intr_at) ? intr_amt : 8'($urandom);
      n++;
      @(negedge clk);
    end
    refund_req = 1'b0;
    if (!seen_done) check($sformatf("timeout_%0d", amt), 0, 1);
    check($sformatf("busy_cycles_%0d", amt), busy_cnt, done_at);
    check($sformatf("missing_coins_%0d", amt), exp_q.size(), 0);
`ifndef COIN_INVENTORY_EN
    if (exp_n >= 0) check($sformatf("coin_count_%0d", amt), coin_cnt, exp_n);
`endif
    for (int i = 0; i < 3; i++) begin
      check_quiet($sformatf("after_%0d", amt));
      @(negedge clk);
    end
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{8'd87,  -1, 8'd0,  7};
    vecs[1]  = '{8'd0,   -1, 8'd0,  0};
    vecs[2]  = '{8'd255,  3, 8'd20, 6};
    vecs[3]  = '{8'd99,  -1, 8'd0,  10};
    vecs[4]  = '{8'd1,   -1, 8'd0,  1};
    vecs[5]  = '{8'd5,    0, 8'd7,  1};
    vecs[6]  = '{8'd5,    1, 8'd9,  1};
    vecs[7]  = '{8'd49,  -1, 8'd0,  9};
    vecs[8]  = '{8'd50,  -1, 8'd0,  1};
    vecs[9]  = '{8'd16,   2, 8'd40, 3};
    vecs[10] = '{8'd0,    0, 8'd33, 0};

    reset = 1'b0;
    refund_req = 1'b0;
    refund_amount = 8'd0;
    reload_stock();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_quiet("idle");
    end

    for (int i = 0; i < 11; i++) begin
      do_refund(vecs[i].amt, vecs[i].intr_at, vecs[i].intr_amt, vecs[i].exp_n);
    end

    // Reset while the third coin of an 87 refund is on the outputs.
    apply_reset();
    @(negedge clk);
    refund_req = 1'b1;
    refund_amount = 8'd87;
    @(negedge clk);
    refund_req = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_third_coin", int'(coin_out), 10);
    reset = 1'b0;
    @(negedge clk);
    check_quiet("abort");
    check("abort_remaining", int'(remaining), 0);
    reset = 1'b1;
    reload_stock();
    @(negedge clk);
    check_quiet("abort_idle");
    do_refund(8'd15, -1, 8'd0, 2);

`ifdef COIN_INVENTORY_EN
    // Limited stock: 80 pays 50,10,10,5,1,1 and leaves 3 unpaid.
    apply_reset();
    do_refund(8'd80, -1, 8'd0, 6);
    check("inv_error_sticky", int'(error), 1);
    check("inv_remaining_held", int'(remaining), 3);
    do_refund(8'd1, -1, 8'd0, 0);
    check("inv_error_again", int'(error), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
